// File: rtl/register_file_arbiter_pkg.sv
// register_file_arbiter_pkg: FSM states, requester ids and helpers shared by the arbiter files.
package register_file_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT} state_e;

    localparam logic SYSTEM_CONTROLLER = 1'b0;
    localparam logic DEBUG_HOST        = 1'b1;

    function automatic int address_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [1:0] requester_mask(input logic idx);
        return (idx == DEBUG_HOST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/register_file_arbiter_selector.sv
// round_robin_selector_2: picks the sole requester, or on a tie the one not granted last.
module round_robin_selector_2
    import register_file_arbiter_pkg::*;
(
    input  logic [1:0] request_i,
    input  logic       last_granted_i,
    output logic       winner_o,
    output logic       any_request_o
);

    assign any_request_o = |request_i;
    assign winner_o      = (request_i == 2'b11) ? ~last_granted_i
                         : (request_i[DEBUG_HOST] ? DEBUG_HOST : SYSTEM_CONTROLLER);

endmodule

// File: rtl/register_file_arbiter.sv
// register_file_arbiter: round-robin sharing of the register-file port between two requesters,
// one command per grant, read data routed back to the issuer, reads abandoned after a timeout.
module register_file_arbiter
    import register_file_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int READ_TIMEOUT_CYCLES = 7,
    localparam int ADDRESS_WIDTH      = address_width(REGISTER_FILE_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 request,
    input  logic [1:0]                 request_write,
    input  logic [2*ADDRESS_WIDTH-1:0] request_address,
    input  logic [2*DATA_WIDTH-1:0]    request_write_data,
    output logic [1:0]                 grant,
    output logic [1:0]                 read_data_valid,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic [1:0]                 read_timeout,
    output logic [ADDRESS_WIDTH-1:0]   register_file_address,
    output logic                       register_file_write_enable,
    output logic [DATA_WIDTH-1:0]      register_file_write_data,
    output logic                       register_file_read_enable,
    input  logic                       register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0]      register_file_read_data
);

    state_e                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     winner_q, winner_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [1:0]               rdv_q, rdv_d;
    logic [1:0]               to_q, to_d;
    logic                     sel_winner;
    logic                     any_request;

    round_robin_selector_2 u_selector (
        .request_i      (request),
        .last_granted_i (last_q),
        .winner_o       (sel_winner),
        .any_request_o  (any_request)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        rdv_d    = 2'b00;
        to_d     = 2'b00;
        case (state_q)
            IDLE: if (any_request) begin
                state_d  = ISSUE;
                last_d   = sel_winner;
                winner_d = sel_winner;
                write_d  = request_write[sel_winner];
                addr_d   = sel_winner ? request_address[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                      : request_address[ADDRESS_WIDTH-1:0];
                wdata_d  = sel_winner ? request_write_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : request_write_data[DATA_WIDTH-1:0];
            end
            ISSUE: begin
                state_d = write_q ? IDLE : READ_WAIT;
                cnt_d   = 8'd0;
            end
            READ_WAIT: begin
                // valid takes priority over a timeout landing in the same cycle
                if (register_file_read_data_valid) begin
                    rdata_d = register_file_read_data;
                    rdv_d   = requester_mask(winner_q);
                    state_d = IDLE;
                end else if (cnt_q == 8'(READ_TIMEOUT_CYCLES)) begin
                    to_d    = requester_mask(winner_q);
                    state_d = IDLE;
                end else begin
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= DEBUG_HOST;
            winner_q <= SYSTEM_CONTROLLER;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= 8'd0;
            rdv_q    <= 2'b00;
            to_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            rdv_q    <= rdv_d;
            to_q     <= to_d;
        end
    end

    assign grant                      = (state_q == ISSUE) ? requester_mask(winner_q) : 2'b00;
    assign register_file_write_enable = (state_q == ISSUE) && write_q;
    assign register_file_read_enable  = (state_q == ISSUE) && !write_q;
    assign register_file_address      = addr_q;
    assign register_file_write_data   = wdata_q;
    assign read_data                  = rdata_q;
    assign read_data_valid            = rdv_q;
    assign read_timeout               = to_q;

endmodule

// File: tb/tb_register_file_arbiter.sv
// tb_register_file_arbiter: scoreboard bench with a small register-file model behind the arbiter.
module tb_register_file_arbiter;

    localparam int T = 7;

    typedef struct { logic [1:0] g; logic wr; logic [3:0] a; logic [7:0] d; } gexp_t;
    typedef struct { logic [1:0] v; logic [1:0] t; logic [7:0] d; } rexp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] request = 2'b00;
    logic [1:0] request_write = 2'b00;
    logic [7:0] request_address = '0;
    logic [15:0] request_write_data = '0;
    logic [1:0] grant, read_data_valid, read_timeout;
    logic [7:0] read_data, rf_wdata, rf_rdata, pend_data;
    logic [3:0] rf_addr;
    logic       rf_we, rf_re, rf_valid_m, rf_rvalid;
    logic       stray = 1'b0;
    logic [7:0] mem [16];
    int         rf_delay = 1;
    int         pend_cnt;
    int         cyc = 0;
    int         n_cmp = 0, n_bad = 0;
    int         n_grant = 0, n_resp = 0;
    int         grant_cyc = 0, resp_cyc = 0;
    gexp_t      gq[$];
    rexp_t      rq[$];
    gexp_t      ge;
    rexp_t      rx;

    register_file_arbiter dut (
        .clk                           (clk),
        .reset                         (reset),
        .request                       (request),
        .request_write                 (request_write),
        .request_address               (request_address),
        .request_write_data            (request_write_data),
        .grant                         (grant),
        .read_data_valid               (read_data_valid),
        .read_data                     (read_data),
        .read_timeout                  (read_timeout),
        .register_file_address         (rf_addr),
        .register_file_write_enable    (rf_we),
        .register_file_write_data      (rf_wdata),
        .register_file_read_enable     (rf_re),
        .register_file_read_data_valid (rf_rvalid),
        .register_file_read_data       (rf_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rf_rvalid = rf_valid_m | stray;

    // register file: answers a read rf_delay cycles after the strobe, never when rf_delay is 0
    always @(posedge clk) begin
        rf_valid_m <= 1'b0;
        if (reset) begin
            pend_cnt <= 0;
        end else begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            if (rf_re) begin
                if (rf_delay == 1) begin
                    rf_valid_m <= 1'b1;
                    rf_rdata   <= mem[rf_addr];
                end
                pend_cnt  <= (rf_delay > 1) ? rf_delay - 1 : 0;
                pend_data <= mem[rf_addr];
            end else if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    rf_valid_m <= 1'b1;
                    rf_rdata   <= pend_data;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (grant != 2'b00) begin
            grant_cyc = cyc;
            n_grant++;
            if (gq.size() == 0) check("spurious_grant", {30'd0, grant}, 32'd0);
            else begin
                ge = gq.pop_front();
                check("grant", {30'd0, grant}, {30'd0, ge.g});
                check("strobes", {30'd0, rf_we, rf_re}, ge.wr ? 32'd2 : 32'd1);
                check("rf_addr", {28'd0, rf_addr}, {28'd0, ge.a});
                if (ge.wr) check("rf_wdata", {24'd0, rf_wdata}, {24'd0, ge.d});
            end
        end
        if ((read_data_valid | read_timeout) != 2'b00) begin
            resp_cyc = cyc;
            n_resp++;
            if (rq.size() == 0) check("spurious_resp", {28'd0, read_data_valid, read_timeout}, 32'd0);
            else begin
                rx = rq.pop_front();
                check("rdv", {30'd0, read_data_valid}, {30'd0, rx.v});
                check("rto", {30'd0, read_timeout}, {30'd0, rx.t});
                if (rx.v != 2'b00) check("rdata", {24'd0, read_data}, {24'd0, rx.d});
            end
        end
    end

    task automatic wait_grants(input int n);
        for (int i = 0; i < 60 && n_grant < n; i++) begin
            @(negedge clk);
            #1;
        end
        check("wait_grant", n_grant, n);
    endtask

    task automatic wait_resps(input int n);
        for (int i = 0; i < 60 && n_resp < n; i++) begin
            @(negedge clk);
            #1;
        end
        check("wait_resp", n_resp, n);
    endtask

    task automatic drive(input int idx, input logic wr, input logic [3:0] a, input logic [7:0] d);
        request[idx]               = 1'b1;
        request_write[idx]         = wr;
        request_address[idx*4 +: 4] = a;
        request_write_data[idx*8 +: 8] = d;
    endtask

    task automatic issue(input int idx, input logic wr, input logic [3:0] a, input logic [7:0] d);
        int c0, n0;
        @(negedge clk);
        drive(idx, wr, a, d);
        c0 = cyc;
        n0 = n_grant;
        wait_grants(n0 + 1);
        request[idx] = 1'b0;
        check("grant_lat", grant_cyc - c0, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_resp", {28'd0, read_data_valid, read_timeout}, 32'd0);
        check("rst_strobes", {30'd0, rf_we, rf_re}, 32'd0);
        check("rst_addr_data", {20'd0, rf_addr, rf_wdata}, 32'd0);
        check("rst_rdata", {24'd0, read_data}, 32'd0);
    endtask

    initial begin
        int nr, ng;
        // both requesters held through reset, then alternating grants starting with requester 0
        drive(0, 1'b1, 4'h1, 8'h11);
        drive(1, 1'b1, 4'h4, 8'h44);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        gq.push_back('{2'b01, 1'b1, 4'h1, 8'h11});
        gq.push_back('{2'b10, 1'b1, 4'h4, 8'h44});
        gq.push_back('{2'b01, 1'b1, 4'h1, 8'h11});
        reset = 1'b0;
        wait_grants(3);
        request = 2'b00;
        repeat (2) @(negedge clk);

        // requester 1 writes A5 to register 3 and reads it back
        gq.push_back('{2'b10, 1'b1, 4'h3, 8'hA5});
        issue(1, 1'b1, 4'h3, 8'hA5);
        repeat (2) @(negedge clk);
        nr = n_resp;
        gq.push_back('{2'b10, 1'b0, 4'h3, 8'h00});
        rq.push_back('{2'b10, 2'b00, 8'hA5});
        issue(1, 1'b0, 4'h3, 8'h00);
        wait_resps(nr + 1);
        check("read_lat", resp_cyc - grant_cyc, 2);
        repeat (2) @(negedge clk);

        // requester 0 reads 0x81 from register 2
        gq.push_back('{2'b01, 1'b1, 4'h2, 8'h81});
        issue(0, 1'b1, 4'h2, 8'h81);
        repeat (2) @(negedge clk);
        check("rdata_hold", {24'd0, read_data}, 32'hA5);
        nr = n_resp;
        gq.push_back('{2'b01, 1'b0, 4'h2, 8'h00});
        rq.push_back('{2'b01, 2'b00, 8'h81});
        issue(0, 1'b0, 4'h2, 8'h00);
        wait_resps(nr + 1);
        check("read_lat0", resp_cyc - grant_cyc, 2);
        repeat (2) @(negedge clk);

        // lost valid: requester 0 times out, pending requester 1 is served right after
        rf_delay = 0;
        nr = n_resp;
        gq.push_back('{2'b01, 1'b0, 4'h5, 8'h00});
        issue(0, 1'b0, 4'h5, 8'h00);
        ng = n_grant;
        rq.push_back('{2'b00, 2'b01, 8'h00});
        gq.push_back('{2'b10, 1'b1, 4'h6, 8'h66});
        drive(1, 1'b1, 4'h6, 8'h66);
        wait_resps(nr + 1);
        check("timeout_lat", resp_cyc - grant_cyc, T + 2);
        wait_grants(ng + 1);
        request[1] = 1'b0;
        check("serve_other_lat", grant_cyc - resp_cyc, 1);
        check("rdata_hold2", {24'd0, read_data}, 32'h81);
        repeat (2) @(negedge clk);

        // valid arriving on the last timeout cycle wins
        rf_delay = T + 1;
        nr = n_resp;
        gq.push_back('{2'b01, 1'b0, 4'h2, 8'h00});
        rq.push_back('{2'b01, 2'b00, 8'h81});
        issue(0, 1'b0, 4'h2, 8'h00);
        wait_resps(nr + 1);
        check("coincide_lat", resp_cyc - grant_cyc, T + 2);
        repeat (2) @(negedge clk);

        // reset during READ_WAIT, stray valid afterwards, then tie goes to requester 0
        rf_delay = 0;
        gq.push_back('{2'b01, 1'b0, 4'h2, 8'h00});
        issue(0, 1'b0, 4'h2, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rf_delay = 1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (10) @(negedge clk);
        ng = n_grant;
        gq.push_back('{2'b01, 1'b1, 4'h7, 8'h77});
        drive(0, 1'b1, 4'h7, 8'h77);
        drive(1, 1'b1, 4'h8, 8'h88);
        nr = cyc;
        wait_grants(ng + 1);
        request = 2'b00;
        check("tie_after_reset_lat", grant_cyc - nr, 1);
        repeat (4) @(negedge clk);

        check("gq_empty", gq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file_arbiter.md
Name: register_file_arbiter

Overview:
- Shares the single register-file access port between two requesters: requester 0 is the system controller and requester 1 is a debug/configuration host.
- Arbitrates with a round-robin policy and issues exactly one read or write per grant.
- Routes the read data back to the requester that issued the read.
- Sits in the reference-clock domain, between the requesters and register_file; a read-timeout prevents a lost valid from locking the port.

Parameters:
- DATA_WIDTH, 8, register data width.
- REGISTER_FILE_DEPTH, 16, number of registers; ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH) (localparam).
- READ_TIMEOUT_CYCLES, 7, maximum cycles to wait for register_file_read_data_valid; legal range 1..255.

Ports:
- clk  input  1  reference clock.
- reset  input  1  asynchronous, active-high reset.
- request  input  2  bit i is the access request from requester i.
- request_write  input  2  bit i: 1 = write, 0 = read.
- request_address  input  2*ADDRESS_WIDTH  slice i is requester i's address.
- request_write_data  input  2*DATA_WIDTH  slice i is requester i's write data.
- grant  output  2  one-cycle pulse; command of requester i issued this cycle.
- read_data_valid  output  2  one-cycle pulse to the requester that issued the read.
- read_data  output  DATA_WIDTH  returned data, meaningful while read_data_valid is high.
- read_timeout  output  2  one-cycle pulse; the read was abandoned.
- register_file_address  output  ADDRESS_WIDTH  registered address to register_file.
- register_file_write_enable  output  1  one-cycle write strobe.
- register_file_write_data  output  DATA_WIDTH  registered write data.
- register_file_read_enable  output  1  one-cycle read strobe.
- register_file_read_data_valid  input  1  read data valid from register_file.
- register_file_read_data  input  DATA_WIDTH  read data from register_file.

Behaviour:
- Reset: all outputs 0, state IDLE, last_granted = 1 (requester 0 wins the first tie), timeout counter 0. Any in-flight read is discarded and no response is generated for it.
- FSM states: IDLE, ISSUE, READ_WAIT.
- IDLE:
  - If any request bit is set, select the winner: the sole requester, or on a tie the requester != last_granted.
  - Register the winner's address, data and write bit; update last_granted; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert grant[winner].
  - Assert register_file_write_enable or register_file_read_enable; the address and data registers stay stable.
  - Write: go to IDLE.
  - Read: clear the counter and go to READ_WAIT.
- READ_WAIT:
  - On register_file_read_data_valid: next cycle read_data <= register_file_read_data and read_data_valid[winner] pulses; go to IDLE.
  - Otherwise increment the counter. When counter == READ_TIMEOUT_CYCLES, pulse read_timeout[winner] next cycle and go to IDLE.
  - Valid and timeout in the same cycle: valid wins.
- Handshake rules:
  - A requester holds request, write, address and data stable until it sees grant, and deasserts request in the following cycle.
  - A request bit still high in IDLE is a new request.
- Latency (request sampled in IDLE at cycle N):
  - Strobe and grant at N+1.
  - Register file valid expected at N+2; read_data_valid at N+3.
  - Next strobe no earlier than N+3 after a write, or N+4 after a read.
- Other rules:
  - register_file_read_data_valid outside READ_WAIT is ignored.
  - read_data holds its last value between responses.
  - grant, read_data_valid and read_timeout are one-hot or zero.
  - Write and read strobes never assert in the same cycle.
  - The counter saturates and never wraps.
  - Address width equals the register-file index width, so there is no out-of-range check.

Decomposition:
- Shared package: FSM state encoding localparams (IDLE, ISSUE, READ_WAIT), requester index constants (SYSTEM_CONTROLLER = 0, DEBUG_HOST = 1), and the ADDRESS_WIDTH derivation.
- One natural sub-module, round_robin_selector_2: inputs request[1:0] and last_granted; output winner index plus any_request.

Test Plan:
- Reset with request=2'b11 held → outputs stay 0 during reset. After release, the first grant is 2'b01, then 2'b10, then 2'b01 (alternating while both are held).
- Requester 1 writes 0xA5 to address 3 alone → at N+1, grant=2'b10, register_file_write_enable=1, address=3, write_data=0xA5. Register 3 reads back 0xA5.
- Requester 0 reads address 2; register file returns 0x81 at N+2 → read_data_valid=2'b01 and read_data=0x81 at N+3; requester 1 sees no pulse.
- Read with register_file_read_data_valid forced low → read_timeout pulses on the issuing requester exactly READ_TIMEOUT_CYCLES+1 cycles after entering READ_WAIT; FSM returns to IDLE and serves the other requester next.
- Reset asserted in READ_WAIT, then a stray register_file_read_data_valid after release → no read_data_valid or read_timeout; state IDLE; last_granted = 1.
- Valid and timeout coincide (valid arrives on the READ_TIMEOUT_CYCLES cycle) → read_data_valid pulses, read_timeout stays 0.
